// File: rtl/pipe_scheduler.sv
// Pipe scheduler: scrolls a 16x16 pipe playfield, injects template columns at a fixed
// gap, counts pipes passing the bird column and runs a 4-bit LFSR for pattern selection.
module pipe_scheduler #(
  parameter int unsigned SPAWN_GAP = 6,
  parameter int unsigned BIRD_COL  = 12
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  start_i,
  input  logic                  halt_i,
  input  logic                  step_i,
  input  logic [15:0][15:0]     pattern_i,
  output logic [3:0]            random_o,
  output logic [15:0][15:0]     grid_o,
  output logic                  spawned_o,
  output logic [7:0]            score_o,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRun    = 2'b01,
    StFrozen = 2'b10
  } state_e;

  localparam logic [3:0] GapLast = 4'(SPAWN_GAP - 1);

  state_e           state_q, state_d;
  logic [3:0]       lfsr_q, lfsr_d;
  logic [15:0][15:0] grid_q, grid_d;
  logic [7:0]       score_q, score_d;
  logic [3:0]       gap_q, gap_d;
  logic             spawned_q, spawned_d;

  logic             col_hit;
  logic             inject;
  logic             unused_pattern;

  // Only bit 0 of each template row feeds the playfield.
  always_comb begin
    unused_pattern = 1'b0;
    for (int r = 0; r < 16; r++) begin
      unused_pattern = unused_pattern ^ (^pattern_i[r][15:1]);
    end
  end

  // Bird-column occupancy before the shift, and whether this step injects.
  always_comb begin
    col_hit = 1'b0;
    for (int r = 0; r < 16; r++) begin
      col_hit = col_hit | grid_q[r][BIRD_COL];
    end
    inject = (gap_q == GapLast);
  end

  // Next-state logic; halt outranks step and start while running.
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    grid_d    = grid_q;
    score_d   = score_q;
    gap_d     = gap_q;
    spawned_d = 1'b0;

    if (state_q != StFrozen) begin
      lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    end

    unique case (state_q)
      StIdle: begin
        grid_d  = '0;
        score_d = '0;
        if (start_i) begin
          state_d = StRun;
          gap_d   = GapLast;
        end
      end
      StRun: begin
        if (halt_i) begin
          state_d = StFrozen;
        end else if (step_i) begin
          for (int r = 0; r < 16; r++) begin
            grid_d[r] = {grid_q[r][14:0], inject & pattern_i[r][0]};
          end
          gap_d     = inject ? 4'd0 : gap_q + 4'd1;
          spawned_d = inject;
          if (col_hit && (score_q != 8'hff)) begin
            score_d = score_q + 8'd1;
          end
        end
      end
      StFrozen: begin
        if (start_i && !halt_i) begin
          state_d = StRun;
          grid_d  = '0;
          score_d = '0;
          gap_d   = GapLast;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= StIdle;
      lfsr_q    <= 4'b1001;
      grid_q    <= '0;
      score_q   <= '0;
      gap_q     <= '0;
      spawned_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      grid_q    <= grid_d;
      score_q   <= score_d;
      gap_q     <= gap_d;
      spawned_q <= spawned_d;
    end
  end

  assign random_o  = lfsr_q;
  assign grid_o    = grid_q;
  assign spawned_o = spawned_q;
  assign score_o   = score_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Bench for pipe_scheduler: directed scenarios plus randomized traffic, all checked
// against an arithmetic reference model of the playfield.
module tb_pipe_scheduler;

  localparam int unsigned SpawnGap = 6;
  localparam int unsigned BirdCol  = 12;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic              halt;
  logic              step;
  logic [15:0][15:0] pattern;
  logic [3:0]        random;
  logic [15:0][15:0] grid;
  logic              spawned;
  logic [7:0]        score;
  logic [1:0]        state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: state as 0/1/2, rows as integers, counter of steps since a spawn.
  int m_state;
  int m_lfsr;
  int m_grid[16];
  int m_score;
  int m_since;
  int m_spawned;

  pipe_scheduler #(
    .SPAWN_GAP(SpawnGap),
    .BIRD_COL (BirdCol)
  ) dut (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .start_i  (start),
    .halt_i   (halt),
    .step_i   (step),
    .pattern_i(pattern),
    .random_o (random),
    .grid_o   (grid),
    .spawned_o(spawned),
    .score_o  (score),
    .state_o  (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_state   = 0;
    m_lfsr    = 9;
    m_score   = 0;
    m_since   = 0;
    m_spawned = 0;
    for (int r = 0; r < 16; r++) m_grid[r] = 0;
  endfunction

  function automatic void model_clock();
    int nb;
    int hit;
    int inj;
    m_spawned = 0;
    if (m_state != 2) begin
      nb     = ((m_lfsr / 8) + (m_lfsr / 4)) % 2;
      m_lfsr = (m_lfsr * 2) % 16 + nb;
    end
    case (m_state)
      0: begin
        for (int r = 0; r < 16; r++) m_grid[r] = 0;
        m_score = 0;
        if (start) begin
          m_state = 1;
          m_since = SpawnGap - 1;
        end
      end
      1: begin
        if (halt) begin
          m_state = 2;
        end else if (step) begin
          hit = 0;
          for (int r = 0; r < 16; r++) begin
            if ((m_grid[r] / (1 << BirdCol)) % 2 == 1) hit = 1;
          end
          inj = (m_since == SpawnGap - 1) ? 1 : 0;
          for (int r = 0; r < 16; r++) begin
            m_grid[r] = (m_grid[r] * 2 + (inj ? int'(pattern[r][0]) : 0)) % 65536;
          end
          m_since   = inj ? 0 : m_since + 1;
          m_spawned = inj;
          if (hit && m_score < 255) m_score = m_score + 1;
        end
      end
      default: begin
        if (start && !halt) begin
          m_state = 1;
          m_score = 0;
          m_since = SpawnGap - 1;
          for (int r = 0; r < 16; r++) m_grid[r] = 0;
        end
      end
    endcase
  endfunction

  task automatic compare_all();
    logic [255:0] eg;
    eg = '0;
    for (int r = 0; r < 16; r++) eg[r*16 +: 16] = m_grid[r][15:0];
    check_eq("state", 256'(state), 256'(m_state));
    check_eq("random", 256'(random), 256'(m_lfsr));
    check_eq("score", 256'(score), 256'(m_score));
    check_eq("spawned", 256'(spawned), 256'(m_spawned));
    check_eq("grid", grid, eg);
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
    compare_all();
  endtask

  initial begin
    logic [3:0]   seq[5];
    logic [255:0] exp_grid;
    int           spawns;

    seq[0] = 4'b1001; seq[1] = 4'b0011; seq[2] = 4'b0110; seq[3] = 4'b1101; seq[4] = 4'b1010;
    reset_n = 1'b0;
    start   = 1'b0;
    halt    = 1'b0;
    step    = 1'b0;
    pattern = '0;
    model_reset();
    #12;
    reset_n = 1'b1;
    #1;

    // Reset values and the idle LFSR sequence.
    check_eq("rst_state", 256'(state), 256'(0));
    check_eq("rst_grid", grid, 256'(0));
    check_eq("rst_score", 256'(score), 256'(0));
    check_eq("rst_spawned", 256'(spawned), 256'(0));
    check_eq("lfsr_seq0", 256'(random), 256'(seq[0]));
    for (int i = 1; i < 5; i++) begin
      step = (i == 2);
      tick();
      check_eq("lfsr_seq", 256'(random), 256'(seq[i]));
      check_eq("idle_grid", grid, 256'(0));
    end
    step = 1'b0;

    // Start, then a single injecting step with rows 1..4 empty.
    for (int r = 0; r < 16; r++) pattern[r] = (r >= 1 && r <= 4) ? 16'h0000 : 16'hfffd;
    start = 1'b1;
    tick();
    check_eq("start_spawned", 256'(spawned), 256'(0));
    start = 1'b0;
    step  = 1'b1;
    tick();
    exp_grid = '0;
    for (int r = 0; r < 16; r++) exp_grid[r*16 +: 16] = (r >= 1 && r <= 4) ? 16'h0 : 16'h1;
    check_eq("first_inject", grid, exp_grid);
    check_eq("first_spawned", 256'(spawned), 256'(1));
    check_eq("run_state", 256'(state), 256'(1));
    spawns = 1;

    // Steps 2..13: spawns at 7 and 13.
    for (int i = 2; i <= 13; i++) begin
      tick();
      if (spawned) spawns++;
    end
    check_eq("spawn_count", 256'(spawns), 256'(3));
    check_eq("row0_1041", 256'(grid[0]), 256'(16'h1041));
    check_eq("score_pre14", 256'(score), 256'(0));
    tick();
    check_eq("score_step14", 256'(score), 256'(1));

    // Long run to saturation.
    for (int i = 0; i < 1700; i++) tick();
    check_eq("score_sat", 256'(score), 256'(255));
    for (int i = 0; i < 12; i++) tick();
    check_eq("score_nowrap", 256'(score), 256'(255));

    // Halt with simultaneous step, frozen steps, then restart.
    halt = 1'b1;
    tick();
    check_eq("halt_state", 256'(state), 256'(2));
    halt = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    start = 1'b1;
    step  = 1'b0;
    tick();
    check_eq("restart_grid", grid, 256'(0));
    check_eq("restart_score", 256'(score), 256'(0));
    check_eq("restart_state", 256'(state), 256'(1));
    start = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 15) == 0);
      halt  = ($urandom_range(0, 31) == 0);
      step  = ($urandom_range(0, 1) == 1);
      for (int r = 0; r < 16; r++) pattern[r] = 16'($urandom);
      tick();
    end

    // Asynchronous reset mid-run.
    halt  = 1'b0;
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    step  = 1'b1;
    for (int r = 0; r < 16; r++) pattern[r] = 16'hffff;
    for (int i = 0; i < 8; i++) tick();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("async_state", 256'(state), 256'(0));
    check_eq("async_grid", grid, 256'(0));
    check_eq("async_random", 256'(random), 256'(4'b1001));
    check_eq("async_score", 256'(score), 256'(0));
    check_eq("async_spawned", 256'(spawned), 256'(0));
    #10;
    reset_n = 1'b1;
    tick();
    check_eq("idle_step_grid", grid, 256'(0));
    check_eq("idle_step_state", 256'(state), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_scheduler.md
PIPE_SCHEDULER -- requirements
Module: pipe_scheduler

Interface
REQ-001 Parameters SHALL be: SPAWN_GAP, default 6, steps between pipe injections (2..15); BIRD_COL, default 12, grid column index used for scoring (0..15).
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  level-sampled request to begin or restart a run.
REQ-005 halt  in  1  collision/freeze request from game logic.
REQ-006 step  in  1  one-clk scroll strobe from external frame divider.
REQ-007 pattern  in  16x16  [row][col] pipe template from pattern generator; only bit 0 of each row is used.
REQ-008 random  out  4  LFSR state; drives the pattern generator select; never 4'b0000.
REQ-009 grid  out  16x16  [row][col] pipe playfield; bit 0 = rightmost (entry) column, bit 15 = leftmost.
REQ-010 spawned  out  1  one-clk pulse on the edge a pipe column is injected.
REQ-011 score  out  8  pipes passed, saturating at 255.
REQ-012 state  out  2  00 IDLE, 01 RUN, 10 FROZEN; 11 unused.

Function
REQ-013 The LFSR SHALL update as next = {q[2:0], q[3]^q[2]} on every clk in IDLE and RUN, and hold in FROZEN.
REQ-014 random SHALL equal the LFSR register directly (no extra register stage).
REQ-015 IDLE: grid held all-zero, score held 0; start=1 -> RUN next edge, with gap counter loaded to SPAWN_GAP-1.
REQ-016 RUN, step=1 and halt=0: every row SHALL shift toward the MSB, grid[r] <= {grid[r][14:0], in_bit[r]}, with bit 15 discarded.
REQ-017 in_bit[r] SHALL be pattern[r][0] when gap counter == SPAWN_GAP-1, and 0 otherwise.
REQ-018 On an injecting step, the gap counter SHALL clear to 0 and spawned SHALL pulse high that same edge; otherwise the gap counter SHALL increment by 1.
REQ-019 On every shifting step, if OR over r of grid[r][BIRD_COL] (pre-shift value) is 1, score SHALL increment by 1, saturating at 255.
REQ-020 RUN, step=0: grid, score and gap counter SHALL hold.
REQ-021 RUN, halt=1 -> FROZEN next edge; halt SHALL take priority over a simultaneous step (no shift) and over start.
REQ-022 FROZEN: grid, score, gap counter and LFSR SHALL hold; step is ignored.
REQ-023 FROZEN, start=1 and halt=0 -> RUN next edge, with grid cleared to 0, score cleared to 0, and gap counter loaded to SPAWN_GAP-1.
REQ-024 step SHALL be ignored in IDLE; start SHALL be ignored in RUN.
REQ-025 Latency: grid, score and spawned SHALL reflect a step on the clk edge that samples it (1 cycle); there is no pipelining.
REQ-026 spawned SHALL be low in every cycle other than an injecting step edge.

Reset
REQ-027 reset_n=0 SHALL immediately force state=IDLE, LFSR=4'b1001, grid=0, score=0, gap counter=0 and spawned=0, independent of clk.
REQ-028 Reset asserted mid-RUN or mid-FROZEN SHALL discard all progress; after release, the block SHALL wait in IDLE for start.

Verification
REQ-029 Reset release, 4 clocks in IDLE -> random sequence 1001, 0011, 0110, 1101, 1010; grid=0; state=00.
REQ-030 start, then one step, with pattern bit0 = 1 in all rows except rows 1-4 -> grid[r]=16'h0001 for r in {0,5..15} and grid[1..4]=0; spawned pulses once; state=01.
REQ-031 SPAWN_GAP=6 with 13 steps -> spawns on steps 1, 7 and 13; row 0 then equals 16'h1041 when pattern row 0 bit 0 = 1 on each spawn.
REQ-032 BIRD_COL=12 with steps continuing past the first spawn -> score goes 0->1 on step 14 (the edge where the column leaves bit 12); after a long run score saturates at 255 and does not wrap.
REQ-033 halt and step asserted in the same cycle -> no shift, state=10; further steps leave grid and random unchanged; then start -> grid=0, score=0, state=01.
REQ-034 reset_n pulsed low between edges mid-RUN -> outputs return to reset values without a clk edge; a subsequent step while in IDLE is ignored.
